// File: rtl/dadda_pkg.sv
// Shared constants and types for the dadda_16 multiplier / dadda_acc MAC datapath.
package dadda_pkg;

    // Product width produced by dadda_16 (mul_result)
    localparam int unsigned DADDA_PROD_W = 31;

    // Default accumulator and beat-count widths for dadda_acc
    localparam int unsigned DEF_ACC_W = 40;
    localparam int unsigned DEF_CNT_W = 8;

    // Accumulator control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/dadda_acc_add.sv
// Combinational ACC_W+1-bit accumulate adder: acc + zero-extended product.
// Optional macro DADDA_ACC_SAT_EN: clamp the sum to all ones on carry-out.
module dadda_acc_add
    import dadda_pkg::*;
#(
    parameter int unsigned PROD_W = DADDA_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod_in,
    output logic [ACC_W-1:0]  sum_c,
    output logic              carry_c
);

    logic [ACC_W:0] full_c;

    // Wide add; the extra bit is the overflow carry. A clamped (all-ones)
    // accumulator re-carries on any non-zero product, so the clamp stays sticky.
    always_comb begin
        full_c  = (ACC_W+1)'(acc_in) + (ACC_W+1)'(prod_in);
        carry_c = full_c[ACC_W];
`ifdef DADDA_ACC_SAT_EN
        sum_c   = carry_c ? {ACC_W{1'b1}} : full_c[ACC_W-1:0];
`else
        sum_c   = full_c[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/dadda_acc.sv
// Product accumulator for the dadda_16 MAC datapath: sums 'len' products
// received over a valid/ready stream and presents the sum on an output
// handshake. Optional macro DADDA_ACC_SAT_EN selects saturating accumulation.
module dadda_acc
    import dadda_pkg::*;
#(
    parameter int unsigned PROD_W = DADDA_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic              overflow,
    output logic              busy
);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             prod_ready_q, prod_ready_d;
    logic             acc_valid_q, acc_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] sum_c;
    logic             carry_c;
    logic             beat_c;

    dadda_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_in  (acc_q),
        .prod_in (prod_data),
        .sum_c   (sum_c),
        .carry_c (carry_c)
    );

    assign beat_c = prod_valid & prod_ready_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                if (beat_c) begin
                    acc_d = sum_c;
                    ovf_d = ovf_q | carry_c;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (acc_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        prod_ready_d = (state_d == ST_ACCUM);
        acc_valid_d  = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any partial job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            acc_valid_q  <= acc_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign acc_valid  = acc_valid_q;
    assign acc_data   = acc_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dadda_acc.sv
// Scoreboard bench for dadda_acc (ACC_W=32 so overflow is reachable).
module tb_dadda_acc;

    localparam int unsigned PROD_W = 31;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned CNT_W  = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic              overflow;
    logic              busy;

    int          n_checks;
    int          n_fail;
    int          beats;
    exp_t        sb_q[$];
    int unsigned job_p[$];
    int          job_g[$];

    dadda_acc #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum, then wrap or clamp to ACC_W bits
    function automatic exp_t model(input int unsigned p[$]);
        exp_t            e;
        longint unsigned t;
        t = 0;
        foreach (p[i]) t += 64'(p[i]);
        e.ovf = (t > 64'h0000_0000_FFFF_FFFF);
`ifdef DADDA_ACC_SAT_EN
        e.acc = e.ovf ? 32'hFFFF_FFFF : t[31:0];
`else
        e.acc = t[31:0];
`endif
        return e;
    endfunction

    // Count accepted product beats
    always @(posedge clk) begin
        if (!rst && prod_valid && prod_ready) beats++;
    end

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && acc_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected result", 64'(1), 64'(0));
            end else begin
                chk("acc_data", 64'(acc_data), 64'(sb_q[0].acc));
                chk("overflow", 64'(overflow), 64'(sb_q[0].ovf));
                chk("busy while valid", 64'(busy), 64'(1));
                if (acc_ready) sb_q.delete(0);
            end
        end
    end

    task automatic send_beat(input int unsigned d, input int gap, input bit spur);
        bit got;
        prod_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        prod_valid = 1'b1;
        prod_data  = PROD_W'(d);
        if (spur) begin
            start = 1'b1;
            len   = CNT_W'(3);
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = prod_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        prod_valid = 1'b0;
        chk("beat accepted", 64'(got), 64'(1));
    endtask

    task automatic run_job(input int rdy_dly, input bit spur_accum, input bit spur_done);
        int l;
        bit hs;
        l = job_p.size();
        sb_q.push_back(model(job_p));
        beats = 0;
        start = 1'b1;
        len   = CNT_W'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (l == 0) begin
            @(negedge clk);
            chk("len0 acc_valid next cycle", 64'(acc_valid), 64'(1));
            chk("len0 prod_ready low", 64'(prod_ready), 64'(0));
        end else begin
            foreach (job_p[i]) send_beat(job_p[i], job_g[i], spur_accum && (i == 1));
            @(negedge clk);
            chk("acc_valid latency", 64'(acc_valid), 64'(1));
            chk("prod_ready low in done", 64'(prod_ready), 64'(0));
        end
        repeat (rdy_dly + 1) begin
            @(posedge clk);
            #1;
        end
        acc_ready = 1'b1;
        if (spur_done) begin
            start = 1'b1;
            len   = CNT_W'(2);
        end
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk);
            hs = acc_valid;
            @(posedge clk);
            #1;
        end
        acc_ready = 1'b0;
        start     = 1'b0;
        chk("result handshake", 64'(hs), 64'(1));
        @(negedge clk);
        chk("busy low after handshake", 64'(busy), 64'(0));
        chk("acc_valid low after handshake", 64'(acc_valid), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("still idle", 64'(busy), 64'(0));
        chk("beats accepted", 64'(beats), 64'(l));
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int unsigned a, input int unsigned b,
                           input int unsigned c, input int unsigned d, input int n);
        int unsigned v[4];
        v = '{a, b, c, d};
        job_p.delete();
        job_g.delete();
        for (int i = 0; i < n; i++) begin
            job_p.push_back(v[i]);
            job_g.push_back(0);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        beats      = 0;
        rst        = 1'b0;
        start      = 1'b0;
        len        = '0;
        prod_valid = 1'b0;
        prod_data  = '0;
        acc_ready  = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset acc_valid", 64'(acc_valid), 64'(0));
        chk("reset prod_ready", 64'(prod_ready), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset overflow", 64'(overflow), 64'(0));
        chk("reset acc_data", 64'(acc_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic sum of four products
        set_job(1523990, 1001000, 4002000, 9003000, 4);
        run_job(0, 1'b0, 1'b0);

        // Stalled beats and held-off result
        set_job(1523990, 1001000, 4002000, 9003000, 4);
        job_g[1] = 2;
        run_job(5, 1'b0, 1'b0);

        // Zero-length job
        job_p.delete();
        job_g.delete();
        run_job(0, 1'b0, 1'b0);

        // Overflow on a 32-bit accumulator
        set_job(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 3);
        run_job(1, 1'b0, 1'b0);

        // Asynchronous reset after two of four beats
        start = 1'b1;
        len   = CNT_W'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(1000, 0, 1'b0);
        send_beat(2000, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async rst prod_ready", 64'(prod_ready), 64'(0));
        chk("async rst busy", 64'(busy), 64'(0));
        chk("async rst acc_data", 64'(acc_data), 64'(0));
        chk("async rst acc_valid", 64'(acc_valid), 64'(0));
        chk("async rst overflow", 64'(overflow), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_job(42, 0, 0, 0, 1);
        run_job(0, 1'b0, 1'b0);

        // Spurious starts in ACCUM and on the result handshake
        set_job(7, 11, 13, 17, 4);
        run_job(2, 1'b1, 1'b1);

        // Randomized jobs
        for (int j = 0; j < 24; j++) begin
            int l;
            l = int'($urandom_range(0, 6));
            job_p.delete();
            job_g.delete();
            for (int i = 0; i < l; i++) begin
                if ($urandom_range(0, 1) == 1) job_p.push_back($urandom & 32'h7FFF_FFFF);
                else job_p.push_back($urandom_range(0, 5000));
                job_g.push_back(int'($urandom_range(0, 2)));
            end
            run_job(int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
